controle_multiciclo: RTL and testbench

Parametrised multicycle control unit for the grupo 4 processor datapath. The step sequencing is internal: fetch, decode and execute run from a synchronous state machine, with no external step counter. Instruction fetch uses the PC register and the memory address/data path, and the unit adds add, ld and st to the mv/mvi/sub/mvnz set. The unit drives the register file enables, the A/G/ULA controls, the address/data-out registers and memory write-enable, and reports completion on `Done`.

---
 rtl/uc_pkg.sv | 27 ++
 rtl/decodificador_n.sv | 16 +
 rtl/controle_multiciclo.sv | 170 +++++++++++++++++
 tb/tb_controle_multiciclo.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// Shared types and encodings for the multicycle control unit: FSM states,
// opcode values and ALU operation codes.
package uc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_F0,
    S_F1,
    S_F2,
    S_E1,
    S_E2,
    S_E3,
    S_FIM
  } state_t;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVI  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_MVNZ = 3'b100;
  localparam logic [2:0] OP_LD   = 3'b101;
  localparam logic [2:0] OP_ST   = 3'b110;

  localparam logic [1:0] ULA_ADD = 2'b00;
  localparam logic [1:0] ULA_SUB = 2'b01;

endpackage

// File: rtl/decodificador_n.sv
// Parametrised RSEL_W-to-2**RSEL_W one-hot decoder with enable; output is
// all zero when disabled.
module decodificador_n #(
  parameter int RSEL_W = 3
) (
  input  logic [RSEL_W-1:0]      sel_i,
  input  logic                   en_i,
  output logic [2**RSEL_W-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: fetch (F0-F2), execute (E1-E3) and FIM states.
// Define UC_LDST_EN to implement ld/st; otherwise they decode as illegal.
module controle_multiciclo
  import uc_pkg::*;
#(
  parameter int RSEL_W = 3,
  parameter int OPC_W  = 3
) (
  input  logic                           Clock,
  input  logic                           Resetn,
  input  logic                           Run,
  input  logic [OPC_W+2*RSEL_W-1:0]      Instrucao,
  input  logic                           G_nz,
  output logic                           IRin,
  output logic [2**RSEL_W-1:0]           Rin,
  output logic [2**RSEL_W-1:0]           Rout,
  output logic                           Ain,
  output logic                           Gin,
  output logic                           Gout,
  output logic                           DINout,
  output logic [1:0]                     Ulaop,
  output logic                           ADDRin,
  output logic                           DOUTin,
  output logic                           W_D,
  output logic                           IncrPc,
  output logic                           Done,
  output logic                           Erro
);

  localparam int NREG = 2**RSEL_W;
  localparam int IW   = OPC_W + 2*RSEL_W;
  localparam logic [NREG-1:0] PC_OH = {1'b1, {(NREG-1){1'b0}}};

  state_t state_q, state_d;
  logic   erro_q, erro_set;
  logic   rout_rx, rout_ry, rout_pc, rin_rx;
  logic   exec_phase;
  logic [OPC_W-1:0]  opc;
  logic [RSEL_W-1:0] rx, ry;
  logic [NREG-1:0]   rx_oh, ry_oh;

  assign opc = Instrucao[IW-1 -: OPC_W];
  assign rx  = Instrucao[2*RSEL_W-1 -: RSEL_W];
  assign ry  = Instrucao[RSEL_W-1:0];

  // IR contents are only meaningful once the fetch has completed.
  assign exec_phase = (state_q == S_E1) || (state_q == S_E2) || (state_q == S_E3);

  decodificador_n #(.RSEL_W(RSEL_W)) u_dec_rx (.sel_i(rx), .en_i(exec_phase), .onehot_o(rx_oh));
  decodificador_n #(.RSEL_W(RSEL_W)) u_dec_ry (.sel_i(ry), .en_i(exec_phase), .onehot_o(ry_oh));

  assign Rout = ({NREG{rout_rx}} & rx_oh) | ({NREG{rout_ry}} & ry_oh) | ({NREG{rout_pc}} & PC_OH);
  assign Rin  = {NREG{rin_rx}} & rx_oh;
  assign Erro = erro_q | erro_set;

  always_ff @(posedge Clock) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (Resetn) begin
      state_q <= S_IDLE;
      erro_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      erro_q  <= erro_q | erro_set;
    end
  end

  always_comb begin
    state_d  = state_q;
    erro_set = 1'b0;
    rout_rx  = 1'b0;
    rout_ry  = 1'b0;
    rout_pc  = 1'b0;
    rin_rx   = 1'b0;
    IRin     = 1'b0;
    Ain      = 1'b0;
    Gin      = 1'b0;
    Gout     = 1'b0;
    DINout   = 1'b0;
    Ulaop    = ULA_ADD;
    ADDRin   = 1'b0;
    DOUTin   = 1'b0;
    W_D      = 1'b0;
    IncrPc   = 1'b0;
    Done     = 1'b0;

    case (state_q)
      S_IDLE: if (Run) state_d = S_F0;
      S_F0: begin
        rout_pc = 1'b1;
        ADDRin  = 1'b1;
        state_d = S_F1;
      end
      S_F1: begin
        IncrPc  = 1'b1;
        state_d = S_F2;
      end
      S_F2: begin
        IRin    = 1'b1;
        state_d = S_E1;
      end
      S_E1: begin
        state_d = S_FIM;
        case (opc)
          OPC_W'(OP_MV): begin
            rout_ry = 1'b1;
            rin_rx  = 1'b1;
          end
          OPC_W'(OP_MVI): begin
            rout_pc = 1'b1;
            ADDRin  = 1'b1;
            state_d = S_E2;
          end
          OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
            rout_rx = 1'b1;
            Ain     = 1'b1;
            state_d = S_E2;
          end
          OPC_W'(OP_MVNZ): begin
            rout_ry = G_nz;
            rin_rx  = G_nz;
          end
`ifdef UC_LDST_EN
          OPC_W'(OP_LD), OPC_W'(OP_ST): begin
            rout_ry = 1'b1;
            ADDRin  = 1'b1;
            state_d = S_E2;
          end
`endif
          default: erro_set = 1'b1;
        endcase
      end
      S_E2: begin
        state_d = S_FIM;
        case (opc)
          OPC_W'(OP_MVI): begin
            IncrPc  = 1'b1;
            state_d = S_E3;
          end
          OPC_W'(OP_ADD), OPC_W'(OP_SUB): begin
            rout_ry = 1'b1;
            Gin     = 1'b1;
            Ulaop   = (opc == OPC_W'(OP_SUB)) ? ULA_SUB : ULA_ADD;
            state_d = S_E3;
          end
`ifdef UC_LDST_EN
          OPC_W'(OP_LD): state_d = S_E3;
          OPC_W'(OP_ST): begin
            rout_rx = 1'b1;
            DOUTin  = 1'b1;
            W_D     = 1'b1;
          end
`endif
          default: state_d = S_FIM;
        endcase
      end
      S_E3: begin
        state_d = S_FIM;
        rin_rx  = 1'b1;
        if (opc == OPC_W'(OP_ADD) || opc == OPC_W'(OP_SUB)) Gout = 1'b1;
        else                                                DINout = 1'b1;
      end
      S_FIM: begin
        Done    = 1'b1;
        state_d = Run ? S_F0 : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Scoreboard bench for controle_multiciclo: expected per-cycle output vectors
// are queued when an instruction is launched and compared on the falling edge.
module tb_controle_multiciclo;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       ain;
    logic       gin;
    logic       gout;
    logic       dinout;
    logic [1:0] ulaop;
    logic       addrin;
    logic       doutin;
    logic       w_d;
    logic       incrpc;
    logic       done;
    logic       erro;
  } outs_t;

  logic       Clock, Resetn, Run, G_nz;
  logic [8:0] Instrucao;
  logic       IRin, Ain, Gin, Gout, DINout, ADDRin, DOUTin, W_D, IncrPc, Done, Erro;
  logic [7:0] Rin, Rout;
  logic [1:0] Ulaop;

  outs_t exp_q[$];
  string tag_q[$];
  int    n_checks = 0;
  int    n_errors = 0;
  logic  tb_erro  = 1'b0;

  controle_multiciclo dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run), .Instrucao(Instrucao), .G_nz(G_nz),
    .IRin(IRin), .Rin(Rin), .Rout(Rout), .Ain(Ain), .Gin(Gin), .Gout(Gout),
    .DINout(DINout), .Ulaop(Ulaop), .ADDRin(ADDRin), .DOUTin(DOUTin), .W_D(W_D),
    .IncrPc(IncrPc), .Done(Done), .Erro(Erro)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  task automatic check(input string tag, input outs_t got, input outs_t exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic outs_t base();
    outs_t o;
    o = '0;
    o.erro = tb_erro;
    return o;
  endfunction

  task automatic push(input string tag, input outs_t o);
    exp_q.push_back(o);
    tag_q.push_back(tag);
  endtask

  task automatic step();
    outs_t got, e;
    string t;
    @(negedge Clock);
    got = {IRin, Rin, Rout, Ain, Gin, Gout, DINout, Ulaop, ADDRin, DOUTin, W_D, IncrPc, Done, Erro};
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check(t, got, e);
  endtask

  task automatic drain_all();
    while (exp_q.size() > 0) step();
  endtask

  // Expected cycle sequence for one instruction, F0 through FIM.
  task automatic push_instr(input string name, input logic [8:0] instr, input logic gnz);
    outs_t o;
    logic [2:0] opc, rx, ry;
    opc = instr[8:6];
    rx  = instr[5:3];
    ry  = instr[2:0];
    o = base(); o.rout[7] = 1'b1; o.addrin = 1'b1; push({name, "_F0"}, o);
    o = base(); o.incrpc = 1'b1;                   push({name, "_F1"}, o);
    o = base(); o.irin = 1'b1;                     push({name, "_F2"}, o);
    case (opc)
      3'b000: begin
        o = base(); o.rout[ry] = 1'b1; o.rin[rx] = 1'b1; push({name, "_E1"}, o);
      end
      3'b001: begin
        o = base(); o.rout[7] = 1'b1; o.addrin = 1'b1; push({name, "_E1"}, o);
        o = base(); o.incrpc = 1'b1;                   push({name, "_E2"}, o);
        o = base(); o.dinout = 1'b1; o.rin[rx] = 1'b1; push({name, "_E3"}, o);
      end
      3'b010, 3'b011: begin
        o = base(); o.rout[rx] = 1'b1; o.ain = 1'b1; push({name, "_E1"}, o);
        o = base(); o.rout[ry] = 1'b1; o.gin = 1'b1;
        o.ulaop = (opc == 3'b011) ? 2'b01 : 2'b00;    push({name, "_E2"}, o);
        o = base(); o.gout = 1'b1; o.rin[rx] = 1'b1;  push({name, "_E3"}, o);
      end
      3'b100: begin
        o = base();
        if (gnz) begin
          o.rout[ry] = 1'b1;
          o.rin[rx]  = 1'b1;
        end
        push({name, "_E1"}, o);
      end
`ifdef UC_LDST_EN
      3'b101: begin
        o = base(); o.rout[ry] = 1'b1; o.addrin = 1'b1; push({name, "_E1"}, o);
        o = base();                                     push({name, "_E2"}, o);
        o = base(); o.dinout = 1'b1; o.rin[rx] = 1'b1;  push({name, "_E3"}, o);
      end
      3'b110: begin
        o = base(); o.rout[ry] = 1'b1; o.addrin = 1'b1; push({name, "_E1"}, o);
        o = base(); o.rout[rx] = 1'b1; o.doutin = 1'b1; o.w_d = 1'b1; push({name, "_E2"}, o);
      end
`endif
      default: begin
        tb_erro = 1'b1;
        o = base(); push({name, "_E1"}, o);
      end
    endcase
    o = base(); o.done = 1'b1; push({name, "_FIM"}, o);
  endtask

  // Single instruction from IDLE with a one-cycle Run pulse, then one idle cycle.
  task automatic run_one(input string name, input logic [8:0] instr, input logic gnz);
    Run       = 1'b1;
    Instrucao = instr;
    G_nz      = gnz;
    push_instr(name, instr, gnz);
    step();
    Run = 1'b0;
    drain_all();
    push({name, "_idle"}, base());
    drain_all();
  endtask

  initial begin
    Resetn    = 1'b1;
    Run       = 1'b1;
    G_nz      = 1'b0;
    Instrucao = 9'b000_010_101;
    push("reset_c1", base());
    push("reset_c2", base());
    drain_all();
    Resetn = 1'b0;

    run_one("mv_r2_r5",    9'b000_010_101, 1'b0);
    run_one("sub_r1_r3",   9'b011_001_011, 1'b0);
    run_one("add_r0_r7",   9'b010_000_111, 1'b1);
    run_one("mvi_r3",      9'b001_011_000, 1'b0);
    run_one("mvnz_gnz0",   9'b100_100_000, 1'b0);
    run_one("mvnz_gnz1",   9'b100_100_000, 1'b1);
    run_one("st_r6_r2",    9'b110_110_010, 1'b0);
    run_one("ld_r5_r1",    9'b101_101_001, 1'b0);
    run_one("illegal_111", 9'b111_001_010, 1'b0);
    run_one("mv_sticky",   9'b000_001_010, 1'b0);

    // Back to back with Run held high, reset hits E2 of the second instruction.
    Run       = 1'b1;
    Instrucao = 9'b010_001_010;
    push_instr("b2b_add", Instrucao, 1'b0);
    drain_all();
    Instrucao = 9'b011_011_100;
    push_instr("b2b_sub", Instrucao, 1'b0);
    repeat (5) step();
    Resetn = 1'b1;
    exp_q.delete();
    tag_q.delete();
    tb_erro = 1'b0;
    push("reset_mid", base());
    drain_all();
    Resetn = 1'b0;
    Run    = 1'b0;
    push("idle_after_reset", base());
    drain_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
